// File: rtl/rv_pkg.sv
// Shared RV instruction-format constants and the stage-1 record of the instruction encoder.
package rv_pkg;

    localparam logic [1:0] CLS_I   = 2'b00;
    localparam logic [1:0] CLS_S   = 2'b01;
    localparam logic [1:0] CLS_RSV = 2'b10;
    localparam logic [1:0] CLS_B   = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // A legal immediate is a 12-bit signed value, so only its low 12 bits are kept.
    typedef struct packed {
        logic        legal;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm12;
    } s1_t;

endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with registered head (no fall-through); data_o reads 0 while empty.
module rv_sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          push_i,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          pop_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_full;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty_o   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign w_do_push = push_i & (~w_full | w_do_pop);
    assign data_o    = empty_o ? '0 : r_mem[r_rd_ptr];
    assign count_o   = r_count;

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rv_instr_enc.sv
// Pipelined RV64 I/S/B instruction encoder: stage-1 register, encode mux, output FIFO,
// and a saturating count of dropped (illegal) requests.
module rv_instr_enc
    import rv_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [6:0]           opcode_i,
    input  logic [2:0]           funct3_i,
    input  logic [4:0]           rd_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [63:0]          imm_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          instr_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid holds its payload until taken, ready may depend combinationally on the far side.
    s1_t                  r_s1;
    logic                 r_s1_valid;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 w_legal;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_drain;
    logic                 w_push;
    logic                 w_fifo_empty;
    logic [CNT_W-1:0]     w_fifo_count;
    logic [31:0]          w_enc;
    logic [31:0]          w_head;

    assign w_legal = (opcode_i[6:5] != CLS_RSV) && (imm_i[63:11] == {53{imm_i[11]}});

    assign out_valid_o = ~w_fifo_empty;
    assign w_pop       = out_valid_o & out_ready_i;
    // Illegal entries are dropped and never wait for FIFO space.
    assign w_drain     = r_s1_valid & (~r_s1.legal | (w_fifo_count < CNT_W'(FIFO_DEPTH)) | w_pop);
    assign w_push      = w_drain & r_s1.legal;
    assign in_ready_o  = ~r_s1_valid | w_drain;
    assign w_accept    = in_valid_i & in_ready_o;

    always_comb begin
        w_enc = '0;
        case (r_s1.opcode[6:5])
            CLS_I: w_enc = {r_s1.imm12, r_s1.rs1, r_s1.funct3, r_s1.rd, r_s1.opcode};
            CLS_S: w_enc = {r_s1.imm12[11:5], r_s1.rs2, r_s1.rs1, r_s1.funct3,
                            r_s1.imm12[4:0], r_s1.opcode};
            CLS_B: w_enc = {r_s1.imm12[11], r_s1.imm12[9:4], r_s1.rs2, r_s1.rs1, r_s1.funct3,
                            r_s1.imm12[3:0], r_s1.imm12[10], r_s1.opcode};
            default: w_enc = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid   <= 1'b1;
                r_s1.legal   <= w_legal;
                r_s1.opcode  <= opcode_i;
                r_s1.funct3  <= funct3_i;
                r_s1.rd      <= rd_i;
                r_s1.rs1     <= rs1_i;
                r_s1.rs2     <= rs2_i;
                r_s1.imm12   <= imm_i[11:0];
            end else if (w_drain) begin
                r_s1_valid <= 1'b0;
            end
            r_err <= w_drain & ~r_s1.legal;
            if (w_drain && !r_s1.legal && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    rv_sync_fifo #(
        .DATA_W     (32),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (w_push),
        .data_i  (w_enc),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    assign instr_o   = w_head;
    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_rv_instr_enc.sv
// Bench for rv_instr_enc: table vectors, hand-written timing/backpressure/reset sequences,
// and random requests checked against an arithmetic reference encoder.
module tb_rv_instr_enc;
    import rv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [4:0]  rd_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [63:0] imm_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    rv_instr_enc #(.FIFO_DEPTH(2), .ERR_CNT_W(8)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .opcode_i    (opcode_i),
        .funct3_i    (funct3_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .imm_i       (imm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .instr_o     (instr_o),
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        bit          legal;
        logic [31:0] exp;
    } vec_t;

    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int exp_errcnt = 0;
    int exp_pulses = 0;
    int seen_pulses = 0;
    bit rand_mode = 0;
    bit ready_ctl = 0;
    bit ok;
    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: field placement by plain arithmetic from the format tables.
    function automatic bit ref_legal(input logic [6:0] op, input logic [63:0] imm);
        longint s;
        s = $signed(imm);
        return (int'(op) / 32 != 2) && (s >= -2048) && (s <= 2047);
    endfunction

    function automatic logic [31:0] ref_enc(input vec_t v);
        longint unsigned u, w;
        int cls;
        u   = v.imm & 64'hFFF;
        cls = int'(v.op) / 32;
        w   = longint'(v.op) + longint'(v.f3) * 4096 + longint'(v.rs1) * 32768;
        if (cls == 0) begin
            w = w + longint'(v.rd) * 128 + u * (2 ** 20);
        end else if (cls == 1) begin
            w = w + longint'(v.rs2) * (2 ** 20) + (u % 32) * 128 + (u / 32) * (2 ** 25);
        end else begin
            w = w + longint'(v.rs2) * (2 ** 20) + ((u / 16) % 64) * (2 ** 25)
                  + (u / 2048) * (64'd1 << 31) + (u % 16) * 256 + ((u / 1024) % 2) * 128;
        end
        return w[31:0];
    endfunction

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm);
        vec_t v;
        v.op = op; v.f3 = f3; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.legal = ref_legal(op, imm);
        v.exp   = ref_enc(v);
        return v;
    endfunction

    always @(posedge clk_i) begin
        #2;
        out_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : ready_ctl;
    end

    // Scoreboard: every popped word must be the oldest expected one.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (err_o) seen_pulses++;
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {32'd0, instr_o}, 64'hDEAD_0000_0000);
                end else begin
                    check("pop_word", {32'd0, instr_o}, {32'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge (or timeout).
    task automatic send(input vec_t v, input int budget, output bit acc_ok);
        bit acc;
        in_valid_i = 1'b1;
        opcode_i = v.op; funct3_i = v.f3; rd_i = v.rd; rs1_i = v.rs1; rs2_i = v.rs2; imm_i = v.imm;
        acc_ok = 1'b0;
        for (int c = 0; c < budget && !acc_ok; c++) begin
            @(negedge clk_i);
            acc = in_ready_o;
            @(posedge clk_i);
            #1;
            if (acc) acc_ok = 1'b1;
        end
        in_valid_i = 1'b0;
        if (acc_ok) begin
            if (v.legal) exp_q.push_back(v.exp);
            else begin
                exp_pulses++;
                if (exp_errcnt < 255) exp_errcnt++;
            end
        end
    endtask

    task automatic send_chk(input string name, input vec_t v, input int budget);
        bit a;
        send(v, budget, a);
        check(name, {63'd0, a}, 64'd1);
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) idle(1);
        idle(3);
        check(name, exp_q.size(), 0);
        check({name, "_pulses"}, seen_pulses, exp_pulses);
        check({name, "_errcnt"}, {56'd0, err_cnt_o}, exp_errcnt);
    endtask

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        vec_t v;
        tbl[0] = '{OP_STORE,  3'b011, 5'd0,  5'd2,  5'd8,  64'd16,            1, 32'h0081_3823};
        tbl[1] = '{OP_BRANCH, 3'b000, 5'd0,  5'd1,  5'd2,  64'd4,             1, 32'h0020_8463};
        tbl[2] = '{7'b0010011, 3'b111, 5'd31, 5'd31, 5'd0,  64'd2047,         1, 32'h7FFF_FF93};
        tbl[3] = '{OP_LOAD,   3'b000, 5'd1,  5'd0,  5'd7,  -64'sd2048,        1, 32'h8000_0083};
        tbl[4] = '{OP_BRANCH, 3'b001, 5'd9,  5'd0,  5'd0,  -64'sd1,           1, 32'hFE00_1FE3};
        tbl[5] = '{OP_STORE,  3'b010, 5'd4,  5'd3,  5'd31, -64'sd2048,        1, 32'h81F1_A023};
        tbl[6] = '{OP_LOAD,   3'b000, 5'd1,  5'd1,  5'd1,  -64'sd2049,        0, 32'h0};
        tbl[7] = '{OP_STORE,  3'b000, 5'd1,  5'd1,  5'd1,  64'h1_0000_0000,   0, 32'h0};
        tbl[8] = '{7'b1000011, 3'b000, 5'd1, 5'd1,  5'd1,  64'd0,             0, 32'h0};
        tbl[9] = '{OP_LOAD,   3'b011, 5'd5,  5'd2,  5'd0,  -64'sd8,           1, 32'hFF81_3283};

        idle(3);
        rstn_i = 1'b1;
        @(negedge clk_i);
        check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        check("rst_instr", {32'd0, instr_o}, 64'd0);
        check("rst_err", {63'd0, err_o}, 64'd0);
        check("rst_errcnt", {56'd0, err_cnt_o}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
        @(posedge clk_i); #1;
        ready_ctl = 1;
        idle(2);

        // I-class latency: accept at E0, word visible in the cycle after E1.
        send_chk("i_acc", mk(OP_LOAD, 3'b011, 5'd5, 5'd2, 5'd0, -64'sd8), 10);
        @(negedge clk_i);
        check("i_lat_e0_valid", {63'd0, out_valid_o}, 64'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("i_lat_e1_valid", {63'd0, out_valid_o}, 64'd1);
        check("i_lat_e1_instr", {32'd0, instr_o}, 64'hFF81_3283);
        check("i_lat_e1_err", {63'd0, err_o}, 64'd0);
        @(posedge clk_i); #1;
        idle(2);

        // Illegal immediate: one-cycle err pulse, no FIFO write.
        send_chk("ill_acc", mk(OP_LOAD, 3'b000, 5'd1, 5'd1, 5'd0, 64'd2048), 10);
        @(negedge clk_i);
        check("ill_e0_err", {63'd0, err_o}, 64'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("ill_e1_err", {63'd0, err_o}, 64'd1);
        check("ill_e1_valid", {63'd0, out_valid_o}, 64'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("ill_e2_err", {63'd0, err_o}, 64'd0);
        check("ill_errcnt1", {56'd0, err_cnt_o}, 64'd1);
        @(posedge clk_i); #1;
        send_chk("ill_op_acc", mk(7'b1010011, 3'b000, 5'd1, 5'd1, 5'd1, 64'd0), 10);
        idle(2);
        check("ill_errcnt2", {56'd0, err_cnt_o}, 64'd2);

        for (int i = 0; i < 10; i++) send_chk($sformatf("tbl_acc%0d", i), tbl[i], 10);
        wait_drain("tbl_drain");

        // Backpressure with a 2-deep FIFO.
        ready_ctl = 0;
        idle(2);
        send_chk("bp_acc0", mk(OP_LOAD,   3'd1, 5'd10, 5'd11, 5'd0,  64'd100), 10);
        send_chk("bp_acc1", mk(OP_STORE,  3'd2, 5'd0,  5'd12, 5'd13, -64'sd100), 10);
        send_chk("bp_acc2", mk(OP_BRANCH, 3'd4, 5'd0,  5'd14, 5'd15, 64'd1000), 10);
        v = mk(OP_LOAD, 3'd6, 5'd16, 5'd17, 5'd0, -64'sd1000);
        send(v, 4, ok);
        check("bp_4th_blocked", {63'd0, ok}, 64'd0);
        ready_ctl = 1;
        send(v, 1, ok);
        ready_ctl = 0;
        check("bp_4th_on_pop", {63'd0, ok}, 64'd1);
        @(negedge clk_i);
        check("bp_full_count", {63'd0, in_ready_o}, 64'd0);
        @(posedge clk_i); #1;
        ready_ctl = 1;
        wait_drain("bp_drain");

        // Reset with two words in the FIFO and stage 1 occupied.
        ready_ctl = 0;
        idle(2);
        for (int i = 0; i < 3; i++)
            send_chk("mr_acc", mk(OP_LOAD, 3'd0, 5'(i + 1), 5'd3, 5'd0, 64'(i)), 10);
        @(negedge clk_i);
        check("mr_pre_ready", {63'd0, in_ready_o}, 64'd0);
        @(posedge clk_i); #1;
        rstn_i = 1'b0;
        idle(1);
        rstn_i = 1'b1;
        exp_q.delete();
        exp_errcnt = 0; exp_pulses = 0; seen_pulses = 0;
        @(negedge clk_i);
        check("mr_out_valid", {63'd0, out_valid_o}, 64'd0);
        check("mr_errcnt", {56'd0, err_cnt_o}, 64'd0);
        check("mr_in_ready", {63'd0, in_ready_o}, 64'd1);
        @(posedge clk_i); #1;
        ready_ctl = 1;
        idle(6);
        check("mr_no_stale", {63'd0, out_valid_o}, 64'd0);

        // Random requests with random consumer backpressure.
        rand_mode = 1;
        for (int n = 0; n < 200; n++) begin
            logic [6:0] op;
            logic [63:0] imm;
            int sel;
            sel = $urandom_range(0, 3);
            op  = (sel == 0) ? OP_LOAD : (sel == 1) ? OP_STORE : (sel == 2) ? OP_BRANCH
                                       : 7'($urandom_range(0, 127));
            sel = $urandom_range(0, 9);
            if (sel <= 6)      imm = 64'(longint'($urandom_range(0, 4095)) - 2048);
            else if (sel == 7) imm = {$urandom, $urandom};
            else if (sel == 8) imm = $urandom_range(0, 1) ? 64'd2047 : -64'sd2048;
            else               imm = $urandom_range(0, 1) ? 64'd2048 : -64'sd2049;
            send_chk("rnd_acc", mk(op, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm), 200);
            idle($urandom_range(0, 2));
        end
        rand_mode = 0;
        ready_ctl = 1;
        wait_drain("rnd_drain");

        // Saturation: 300 back-to-back illegal requests.
        for (int n = 0; n < 300; n++) begin
            send_chk("sat_acc", mk(OP_STORE, 3'd0, 5'd0, 5'd1, 5'd2, 64'd4096), 4);
            if (n == 150) begin
                @(negedge clk_i);
                check("sat_err_high", {63'd0, err_o}, 64'd1);
                @(posedge clk_i); #1;
            end
        end
        wait_drain("sat_drain");
        check("sat_errcnt_255", {56'd0, err_cnt_o}, 64'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
